// File: rtl/parity_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module  : parity_frame_serializer
// Brief   : Shifts accepted parallel words out LSB-first on x, each followed
//           by one generated parity bit; frames may run back-to-back.
// Revision: 1.0 - initial release
// ============================================================================
module parity_frame_serializer #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              x,
    output logic              frame_start,
    output logic              frame_end,
    output logic              busy
);

    localparam int                 c_CNT_W    = $clog2(DATA_W + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                r_par;
    logic                w_par_nxt;
    logic                r_x;
    logic                w_x_nxt;
    logic                r_frame_start;
    logic                w_frame_start_nxt;
    logic                r_frame_end;
    logic                w_frame_end_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                w_accept;

    // Ready is held low during reset so no word can be captured then.
    assign din_ready = rst_n && (r_state != ST_DATA);
    assign w_accept  = din_valid && din_ready;

    assign x           = r_x;
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;
    assign busy        = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_shift       <= '0;
            r_cnt         <= '0;
            r_par         <= 1'b0;
            r_x           <= IDLE_LEVEL;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_shift       <= w_shift_nxt;
            r_cnt         <= w_cnt_nxt;
            r_par         <= w_par_nxt;
            r_x           <= w_x_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_frame_end   <= w_frame_end_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_shift_nxt       = r_shift;
        w_cnt_nxt         = r_cnt;
        w_par_nxt         = r_par;
        w_x_nxt           = r_x;
        w_frame_start_nxt = r_frame_start;
        w_frame_end_nxt   = r_frame_end;
        w_busy_nxt        = r_busy;

        case (r_state)
            ST_DATA: begin
                w_frame_start_nxt = 1'b0;
                if (r_cnt < c_CNT_LAST) begin
                    w_x_nxt     = r_shift[0];
                    w_shift_nxt = r_shift >> 1;
                    w_par_nxt   = r_par ^ r_shift[0];
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end else begin
                    w_x_nxt         = r_par ^ PARITY_ODD;
                    w_frame_end_nxt = 1'b1;
                    w_state_nxt     = ST_PAR;
                end
            end

            ST_IDLE, ST_PAR: begin
                if (w_accept) begin
                    // Bit 0 goes straight out; the rest waits in the shifter.
                    w_x_nxt           = din[0];
                    w_shift_nxt       = din >> 1;
                    w_par_nxt         = din[0];
                    w_cnt_nxt         = c_CNT_ONE;
                    w_frame_start_nxt = 1'b1;
                    w_frame_end_nxt   = 1'b0;
                    w_busy_nxt        = 1'b1;
                    w_state_nxt       = ST_DATA;
                end else begin
                    w_x_nxt           = IDLE_LEVEL;
                    w_frame_start_nxt = 1'b0;
                    w_frame_end_nxt   = 1'b0;
                    w_busy_nxt        = 1'b0;
                    w_state_nxt       = ST_IDLE;
                end
            end

            default: begin
                w_x_nxt           = IDLE_LEVEL;
                w_frame_start_nxt = 1'b0;
                w_frame_end_nxt   = 1'b0;
                w_busy_nxt        = 1'b0;
                w_state_nxt       = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
